// File: rtl/axi_crc_master.sv
// AXI-Lite master that streams N_WORDS data words into a CRC slave's
// register file (word addresses 0..N_WORDS-1), then reads the CRC result
// back from address 0. Every AXI wait state is guarded by a cycle counter.
//
// Handshake rule used on every channel: a transfer happens on the rising
// edge where valid and ready are both high; valid, once raised, holds its
// payload stable until that edge and is never withdrawn except by a
// timeout abort or reset.
module axi_crc_master #(
    parameter int N_WORDS = 7,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        areset,
    input  logic [31:0] data_i,
    input  logic        data_valid_i,
    output logic        data_ready_o,
    output logic [31:0] crc_o,
    output logic        crc_valid_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [31:0] awaddr_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    input  logic [1:0]  bresp_i,
    input  logic        bvalid_i,
    output logic        bready_o,
    output logic [31:0] araddr_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [31:0] rdata_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_WRITE = 3'd1,
        S_RESP  = 3'd2,
        S_RADDR = 3'd3,
        S_RDATA = 3'd4
    } state_t;

    // The counter only has to hold 0..TIMEOUT-1: the last value aborts.
    localparam int              WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [3:0]      IDX_LAST  = 4'(N_WORDS - 1);

    state_t              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic [31:0]         awaddr_q, awaddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         crc_q, crc_d;
    logic                crc_valid_q, crc_valid_d;
    logic                err_q, err_d;

    logic                timeout_hit;
    logic                aw_done;
    logic                w_done;

    // State register: all flops, asynchronously cleared
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q     <= S_FETCH;
            idx_q       <= 4'd0;
            wait_q      <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            awaddr_q    <= 32'd0;
            wdata_q     <= 32'd0;
            crc_q       <= 32'd0;
            crc_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            crc_q       <= crc_d;
            crc_valid_q <= crc_valid_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic: batch sequencing, channel tracking and timeout abort
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        crc_d       = crc_q;
        crc_valid_d = 1'b0;
        err_d       = err_q;
        timeout_hit = (wait_q == WAIT_LAST);
        // A channel counts as done if it already completed or completes now
        aw_done     = !awvalid_q || awready_i;
        w_done      = !wvalid_q || wready_i;

        unique case (state_q)
            S_FETCH: begin
                if (data_valid_i) begin
                    wdata_d   = data_i;
                    awaddr_d  = {28'd0, idx_q};
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    // The error flag covers one batch; word 0 starts a new one
                    if (idx_q == 4'd0) begin
                        err_d = 1'b0;
                    end
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (awvalid_q && awready_i) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && wready_i) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done && w_done) begin
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    err_d     = 1'b1;
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    idx_d     = 4'd0;
                    state_d   = S_FETCH;
                end
            end
            S_RESP: begin
                if (bvalid_i) begin
                    if (bresp_i != 2'b00) begin
                        err_d = 1'b1;
                    end
                    if (idx_q == IDX_LAST) begin
                        idx_d   = 4'd0;
                        state_d = S_RADDR;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_FETCH;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    idx_d   = 4'd0;
                    state_d = S_FETCH;
                end
            end
            S_RADDR: begin
                if (arready_i) begin
                    state_d = S_RDATA;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    idx_d   = 4'd0;
                    state_d = S_FETCH;
                end
            end
            S_RDATA: begin
                if (rvalid_i) begin
                    crc_d       = rdata_i;
                    crc_valid_d = 1'b1;
                    state_d     = S_FETCH;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    idx_d   = 4'd0;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
                idx_d   = 4'd0;
            end
        endcase

        // Count cycles spent in a wait state; restart on any state change
        if ((state_d != state_q) || (state_q == S_FETCH)) begin
            wait_d = '0;
        end else begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Output decode: ready/valid strobes straight from the current state
    always_comb begin
        data_ready_o = (state_q == S_FETCH);
        bready_o     = (state_q == S_RESP);
        arvalid_o    = (state_q == S_RADDR);
        rready_o     = (state_q == S_RDATA);
        busy_o       = (state_q != S_FETCH) || (idx_q != 4'd0);
    end

    assign awvalid_o   = awvalid_q;
    assign wvalid_o    = wvalid_q;
    assign awaddr_o    = awaddr_q;
    assign wdata_o     = wdata_q;
    assign wstrb_o     = 4'hF;
    assign araddr_o    = 32'd0;
    assign crc_o       = crc_q;
    assign crc_valid_o = crc_valid_q;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/axi_crc_master.md
AXI_CRC_MASTER -- requirements
Module: axi_crc_master

Interface
REQ-001 Parameter N_WORDS, default 7: words written per batch; SHALL equal the slave's register count (2..16).
REQ-002 Parameter TIMEOUT, default 255: maximum cycles spent waiting in any AXI wait state.
REQ-003 clk  in  1  single clock; all logic is rising-edge.
REQ-004 areset  in  1  asynchronous, active-low reset.
REQ-005 data_i  in  32  next word to write.
REQ-006 data_valid_i  in  1  data_i valid.
REQ-007 data_ready_o  out  1  block accepts data_i.
REQ-008 crc_o  out  32  CRC word read back from the slave.
REQ-009 crc_valid_o  out  1  one-cycle pulse: crc_o updated.
REQ-010 busy_o  out  1  batch in progress.
REQ-011 err_o  out  1  sticky: error response or timeout in the current batch.
REQ-012 awaddr_o  out  32  write address (word index).
REQ-013 awvalid_o  out  1  write address valid.
REQ-014 awready_i  in  1  write address ready.
REQ-015 wdata_o  out  32  write data.
REQ-016 wstrb_o  out  4  byte strobes, constant 4'hF.
REQ-017 wvalid_o  out  1  write data valid.
REQ-018 wready_i  in  1  write data ready.
REQ-019 bresp_i  in  2  write response code.
REQ-020 bvalid_i  in  1  write response valid.
REQ-021 bready_o  out  1  write response ready.
REQ-022 araddr_o  out  32  read address, constant 0.
REQ-023 arvalid_o  out  1  read address valid.
REQ-024 arready_i  in  1  read address ready.
REQ-025 rdata_i  in  32  read data (CRC result).
REQ-026 rvalid_i  in  1  read data valid.
REQ-027 rready_o  out  1  read data ready.

Function
REQ-028 FSM states: FETCH, WRITE, RESP, RADDR, RDATA; a 4-bit word index idx counts 0..N_WORDS-1.
REQ-029 FETCH: data_ready_o=1; on data_valid_i, capture data_i into wdata_o, awaddr_o=idx, enter WRITE next cycle; if idx==0, clear err_o on capture.
REQ-030 WRITE: awvalid_o and wvalid_o both rise the cycle after capture; each drops the cycle after its own handshake (valid&&ready), independently; simultaneous handshakes allowed; enter RESP once both have completed.
REQ-031 Once asserted, awvalid_o/wvalid_o and their address/data SHALL stay stable until handshake.
REQ-032 RESP: bready_o=1; on bvalid_i: bresp_i!=0 sets err_o; if idx==N_WORDS-1 go RADDR with idx=0, else idx+1 and go FETCH.
REQ-033 RADDR: arvalid_o=1 until arready_i, then RDATA; RDATA: rready_o=1; on rvalid_i latch rdata_i into crc_o, pulse crc_valid_o for exactly one cycle, go FETCH.
REQ-034 busy_o=1 whenever state!=FETCH or idx!=0.
REQ-035 A wait counter clears on every state change; reaching TIMEOUT in WRITE, RESP, RADDR or RDATA sets err_o, drops all valid/ready outputs, sets idx=0, returns to FETCH; crc_o unchanged.
REQ-036 data_valid_i is ignored outside FETCH; no data is lost because data_ready_o=0 there.

Reset
REQ-037 areset low (any time, including mid-batch) SHALL immediately force FETCH, idx=0, wait counter=0, all AXI valid/ready outputs 0, awaddr_o/wdata_o/crc_o=0, crc_valid_o=0, err_o=0, busy_o=0, wstrb_o=4'hF, araddr_o=0.

Verification
REQ-038 7 words 0x1..0x7 with slave always ready, bresp=0 -> awaddr 0..6 carry data 0x1..0x7, one read at address 0, crc_o=rdata_i, crc_valid_o one-cycle pulse, err_o=0.
REQ-039 awready_i held 0 for 3 cycles, wready_i immediate -> wvalid_o drops after 1 cycle, awvalid_o held with stable awaddr_o until handshake, then RESP.
REQ-040 bresp_i=2'b10 on word 3 -> err_o=1 through batch end, batch continues, err_o clears when next batch's word 0 is captured.
REQ-041 bvalid_i never asserted, TIMEOUT=255 -> after 255 cycles in RESP: err_o=1, bready_o=0, idx=0, state FETCH.
REQ-042 areset pulled low during RDATA of a batch -> all outputs at reset values that cycle; next batch starts at awaddr_o=0.
